// File: rtl/dmem_responder_pkg.sv
// Shared load/store defines for the data-memory responder and other LSU paths.
package dmem_responder_pkg;

    localparam int DMEM_XLEN = 32;

    // RV32 load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // RV32 store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Responder FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the memory stage (master) and the responder (slave).
// The _i/_o suffixes name each signal from the responder's point of view.
interface dmem_responder_if #(parameter int XLEN = 32);

    logic            req_valid_i;
    logic            req_ready_o;
    logic [XLEN-1:0] req_addr_i;
    logic            req_we_i;
    logic [2:0]      req_func3_i;
    logic [XLEN-1:0] req_wdata_i;
    logic            resp_valid_o;
    logic            resp_ready_i;
    logic [XLEN-1:0] resp_rdata_o;
    logic            resp_err_o;

    modport master (
        output req_valid_i, req_addr_i, req_we_i, req_func3_i, req_wdata_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_we_i, req_func3_i, req_wdata_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
    );

endinterface

// File: rtl/dmem_responder_lsu_fmt.sv
// Combinational RV32 load/store formatter: byte enables, lane-replicated store
// data, sign/zero-extended load data and misalign/illegal flags.
module dmem_lsu_fmt
    import dmem_responder_pkg::*;
(
    input  logic [2:0]  i_func3,
    input  logic [1:0]  i_lane,
    input  logic        i_we,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdataWord,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata,
    output logic        o_misalign,
    output logic        o_illegal
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdataWord[{i_lane, 3'b000} +: 8];
    assign w_half = i_rdataWord[{i_lane[1], 4'b0000} +: 16];

    // Decode funct3 into lane enables, store data, load extension and fault flags
    always_comb begin
        o_be       = 4'b0000;
        o_wdata    = 32'h0;
        o_ldata    = 32'h0;
        o_misalign = 1'b0;
        o_illegal  = 1'b0;
        if (i_we) begin
            case (i_func3)
                F3_SB: begin
                    o_be    = 4'b0001 << i_lane;
                    o_wdata = {4{i_wdata[7:0]}};
                end
                F3_SH: begin
                    o_misalign = i_lane[0];
                    o_be       = i_lane[1] ? 4'b1100 : 4'b0011;
                    o_wdata    = {2{i_wdata[15:0]}};
                end
                F3_SW: begin
                    o_misalign = (i_lane != 2'b00);
                    o_be       = 4'b1111;
                    o_wdata    = i_wdata;
                end
                default: o_illegal = 1'b1;
            endcase
        end else begin
            case (i_func3)
                F3_LB:  o_ldata = {{24{w_byte[7]}}, w_byte};
                F3_LBU: o_ldata = {24'h0, w_byte};
                F3_LH: begin
                    o_misalign = i_lane[0];
                    o_ldata    = {{16{w_half[15]}}, w_half};
                end
                F3_LHU: begin
                    o_misalign = i_lane[0];
                    o_ldata    = {16'h0, w_half};
                end
                F3_LW: begin
                    o_misalign = (i_lane != 2'b00);
                    o_ldata    = i_rdataWord;
                end
                default: o_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, programmable wait states,
// byte-enable backing array, range check and sticky tohost halt flag.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          XLEN        = DMEM_XLEN,
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
)(
    input  logic             clk_i,
    input  logic             rst_i,
    dmem_responder_if.slave  bus,
    output logic             halt_o
);

    localparam int              AW         = $clog2(DEPTH_WORDS);
    localparam logic [XLEN:0]   BYTE_LIMIT = (XLEN+1)'(DEPTH_WORDS) << 2;

    logic [1:0]      r_state;
    logic [3:0]      r_cnt;
    logic [XLEN-1:0] r_addr;
    logic            r_we;
    logic [2:0]      r_func3;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_rdata;
    logic            r_err;
    logic            r_halt;
    logic [XLEN-1:0] r_mem [DEPTH_WORDS];

    logic [XLEN-1:0] w_off;
    logic [AW-1:0]   w_word;
    logic            w_oor;
    logic [XLEN-1:0] w_rdWord;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wword;
    logic [XLEN-1:0] w_loadData;
    logic            w_misalign;
    logic            w_illegal;
    logic            w_err;
    logic            w_accept;
    logic            w_access;
    logic            w_doWrite;
    logic            w_haltHit;
    logic            w_unusedOffLsb;

    // Addresses below BASE_ADDR wrap to huge offsets and fail the range check.
    assign w_off          = r_addr - BASE_ADDR;
    assign w_word         = w_off[AW+1:2];
    assign w_oor          = {1'b0, w_off} >= BYTE_LIMIT;
    assign w_rdWord       = r_mem[w_word];
    assign w_unusedOffLsb = ^w_off[1:0];

    dmem_lsu_fmt u_fmt (
        .i_func3     (r_func3),
        .i_lane      (r_addr[1:0]),
        .i_we        (r_we),
        .i_wdata     (r_wdata),
        .i_rdataWord (w_rdWord),
        .o_be        (w_be),
        .o_wdata     (w_wword),
        .o_ldata     (w_loadData),
        .o_misalign  (w_misalign),
        .o_illegal   (w_illegal)
    );

    assign w_err     = w_misalign | w_illegal | w_oor;
    assign w_accept  = bus.req_valid_i & bus.req_ready_o;
    assign w_access  = (r_state == ST_WAIT) && (r_cnt == 4'd0) && !rst_i;
    assign w_doWrite = w_access && r_we && !w_err;
    assign w_haltHit = w_doWrite && (r_func3 == F3_SW) && (r_addr == TOHOST_ADDR) && r_wdata[0];

    assign bus.req_ready_o  = (r_state == ST_IDLE) && !rst_i;
    assign bus.resp_valid_o = (r_state == ST_RESP);
    assign bus.resp_rdata_o = r_rdata;
    assign bus.resp_err_o   = r_err;
    assign halt_o           = r_halt;

    // Request FSM: latch on accept, count wait states, register the result, hold until taken
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_func3 <= 3'b000;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= bus.req_addr_i;
                        r_we    <= bus.req_we_i;
                        r_func3 <= bus.req_func3_i;
                        r_wdata <= bus.req_wdata_i;
                        r_cnt   <= 4'(WAIT_CYCLES);
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_rdata <= (w_err || r_we) ? '0 : w_loadData;
                        r_err   <= w_err;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Backing array: byte-enable write on a successful store, never cleared by reset
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (w_doWrite && w_be[i]) begin
                r_mem[w_word][8*i +: 8] <= w_wword[8*i +: 8];
            end
        end
    end

    // Sticky halt flag set by a tohost word store with bit 0 high
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_halt <= 1'b0;
        end else if (w_haltHit) begin
            r_halt <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases plus randomized
// transactions compared against a byte-level memory model.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int          W      = 1;
    localparam int          DEPTH  = 4096;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam logic [31:0] TOHOST = 32'h0000_1000;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic halt_o;

    dmem_responder_if bus();

    dmem_responder #(
        .XLEN(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE),
        .WAIT_CYCLES(W), .TOHOST_ADDR(TOHOST)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .bus    (bus),
        .halt_o (halt_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Byte-addressed reference memory and expectation of the outstanding transaction
    logic [7:0]  mdl [DEPTH*4];
    bit          busy    = 1'b0;
    bit          armed   = 1'b0;
    bit          expHalt = 1'b0;
    int          accCyc  = 0;
    logic [31:0] pRdata;
    bit          pErr, pWrite, pHalt;
    logic [31:0] pOff;
    int          pSize;
    logic [31:0] pWdata;

    // Driver bookkeeping
    bit          preValid = 1'b0;
    logic [31:0] preAddr  = 32'h0;
    logic        preWe    = 1'b0;
    logic [2:0]  preF3    = 3'b000;
    logic [31:0] preWd    = 32'h0;
    int          lastAcc, lastHs, lastRise;

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Work out the expected response of one request from the RV32 rules
    function automatic void predict(input logic [31:0] a, input logic we,
                                    input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] off;
        logic [31:0] v;
        int          size;
        bit          sgn, legal, misal, oor;
        off   = a - BASE;
        oor   = (off >= 32'(DEPTH * 4));
        size  = 1;
        sgn   = 1'b0;
        legal = 1'b1;
        if (we) begin
            case (f3)
                3'd0: size = 1;
                3'd1: size = 2;
                3'd2: size = 4;
                default: legal = 1'b0;
            endcase
        end else begin
            case (f3)
                3'd0: begin size = 1; sgn = 1'b1; end
                3'd1: begin size = 2; sgn = 1'b1; end
                3'd2: size = 4;
                3'd4: size = 1;
                3'd5: size = 2;
                default: legal = 1'b0;
            endcase
        end
        misal  = (a % 32'(size)) != 0;
        pErr   = !legal || misal || oor;
        pWrite = we && !pErr;
        pOff   = off;
        pSize  = size;
        pWdata = wd;
        pHalt  = pWrite && (f3 == 3'd2) && (a == TOHOST) && wd[0];
        pRdata = 32'h0;
        if (!pErr && !we) begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(mdl[off + 32'(i)]) << (8 * i));
            if (sgn && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
            pRdata = v;
        end
    endfunction

    // Per-cycle compare of every DUT output against the model
    initial begin : compare
        bit expValid;
        expValid = 1'b0;
        forever begin
            @(negedge clk_i);
            expValid = busy && (cyc >= accCyc + W + 2);
            if (armed) begin
                if (busy && cyc == accCyc + W + 2) begin
                    if (pWrite) for (int i = 0; i < pSize; i++) mdl[pOff + 32'(i)] = pWdata[8*i +: 8];
                    if (pHalt) expHalt = 1'b1;
                end
                checkOutput("resp_valid", 32'(bus.resp_valid_o), 32'(expValid));
                checkOutput("req_ready", 32'(bus.req_ready_o), 32'(!busy && !rst_i));
                checkOutput("halt", 32'(halt_o), 32'(expHalt));
                if (expValid) begin
                    checkOutput("resp_rdata", bus.resp_rdata_o, pRdata);
                    checkOutput("resp_err", 32'(bus.resp_err_o), 32'(pErr));
                end
            end
            if (rst_i) begin
                busy    = 1'b0;
                expHalt = 1'b0;
                armed   = 1'b1;
            end else if (armed) begin
                if (expValid && bus.resp_ready_i) begin
                    busy = 1'b0;
                end else if (!busy && bus.req_valid_i) begin
                    predict(bus.req_addr_i, bus.req_we_i, bus.req_func3_i, bus.req_wdata_i);
                    busy   = 1'b1;
                    accCyc = cyc;
                end
            end
        end
    end

    // One complete transaction; entered and left at 1 time unit after a rising edge
    task automatic applyStimulus(input logic [31:0] a, input logic we, input logic [2:0] f3,
                                 input logic [31:0] wd, input int hold,
                                 output logic [31:0] rd, output logic er);
        int guard, seen, riseCyc;
        bit done;
        rd = 32'h0;
        er = 1'b0;
        bus.req_addr_i  = a;
        bus.req_we_i    = we;
        bus.req_func3_i = f3;
        bus.req_wdata_i = wd;
        bus.req_valid_i = 1'b1;
        guard = 0;
        do begin
            @(negedge clk_i);
            guard++;
        end while (!bus.req_ready_o && guard < 64);
        if (!bus.req_ready_o) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got no req_ready_o expected accept within 64 cycles");
            @(posedge clk_i); #1;
            bus.req_valid_i = 1'b0;
            return;
        end
        lastAcc = cyc;
        @(posedge clk_i); #1;
        bus.req_valid_i = preValid;
        if (preValid) begin
            bus.req_addr_i  = preAddr;
            bus.req_we_i    = preWe;
            bus.req_func3_i = preF3;
            bus.req_wdata_i = preWd;
        end else begin
            bus.req_addr_i  = $urandom;
            bus.req_we_i    = 1'($urandom_range(0, 1));
            bus.req_func3_i = 3'($urandom_range(0, 7));
            bus.req_wdata_i = $urandom;
        end
        bus.resp_ready_i = (hold == 0);
        seen    = 0;
        done    = 1'b0;
        guard   = 0;
        riseCyc = -1;
        while (!done && guard < 64) begin
            @(negedge clk_i);
            guard++;
            if (bus.resp_valid_o) begin
                if (riseCyc < 0) riseCyc = cyc;
                if (bus.resp_ready_i) begin
                    done   = 1'b1;
                    rd     = bus.resp_rdata_o;
                    er     = bus.resp_err_o;
                    lastHs = cyc;
                end else begin
                    seen++;
                end
            end
            @(posedge clk_i); #1;
            bus.resp_ready_i = done ? 1'b0 : (seen >= hold);
        end
        bus.resp_ready_i = 1'b0;
        lastRise = riseCyc;
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL resp_timeout: got no response handshake expected one within 64 cycles");
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] rd;
        logic        er;
        logic [31:0] a;
        int          r, prevHs;

        bus.req_valid_i  = 1'b0;
        bus.req_addr_i   = 32'h0;
        bus.req_we_i     = 1'b0;
        bus.req_func3_i  = 3'b000;
        bus.req_wdata_i  = 32'h0;
        bus.resp_ready_i = 1'b0;

        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("rst_valid", 32'(bus.resp_valid_o), 32'd0);
        checkOutput("rst_rdata", bus.resp_rdata_o, 32'h0);
        checkOutput("rst_err", 32'(bus.resp_err_o), 32'd0);
        checkOutput("rst_halt", 32'(halt_o), 32'd0);
        checkOutput("rst_ready", 32'(bus.req_ready_o), 32'd1);
        @(posedge clk_i); #1;

        // Seed the low region, the reset-test word and the tohost word
        for (int w = 0; w < 128; w++) applyStimulus(32'(w * 4), 1'b1, F3_SW, $urandom, 0, rd, er);
        applyStimulus(32'h200, 1'b1, F3_SW, 32'h1122_3344, 0, rd, er);
        applyStimulus(TOHOST, 1'b1, F3_SW, 32'h0, 0, rd, er);

        $display("[TB] directed word, byte and half accesses");
        applyStimulus(32'h100, 1'b1, F3_SW, 32'hDEAD_BEEF, 0, rd, er);
        checkOutput("sw100_err", 32'(er), 32'd0);
        checkOutput("sw100_rdata", rd, 32'h0);
        checkOutput("sw100_latency", 32'(lastRise - lastAcc), 32'd3);
        applyStimulus(32'h100, 1'b0, F3_LW, 32'h0, 0, rd, er);
        checkOutput("lw100_rdata", rd, 32'hDEAD_BEEF);
        checkOutput("lw100_err", 32'(er), 32'd0);
        checkOutput("lw100_latency", 32'(lastRise - lastAcc), 32'd3);
        applyStimulus(32'h101, 1'b1, F3_SB, 32'h0000_00A5, 0, rd, er);
        checkOutput("sb101_err", 32'(er), 32'd0);
        applyStimulus(32'h101, 1'b0, F3_LB, 32'h0, 1, rd, er);
        checkOutput("lb101", rd, 32'hFFFF_FFA5);
        applyStimulus(32'h101, 1'b0, F3_LBU, 32'h0, 0, rd, er);
        checkOutput("lbu101", rd, 32'h0000_00A5);
        applyStimulus(32'h100, 1'b0, F3_LW, 32'h0, 0, rd, er);
        checkOutput("lw100_after_sb", rd, 32'hDEAD_A5EF);
        applyStimulus(32'h102, 1'b0, F3_LH, 32'h0, 0, rd, er);
        checkOutput("lh102", rd, 32'hFFFF_DEAD);
        applyStimulus(32'h102, 1'b0, F3_LHU, 32'h0, 0, rd, er);
        checkOutput("lhu102", rd, 32'h0000_DEAD);
        applyStimulus(32'h102, 1'b0, F3_LW, 32'h0, 0, rd, er);
        checkOutput("lw102_err", 32'(er), 32'd1);
        checkOutput("lw102_rdata", rd, 32'h0);
        applyStimulus(32'h103, 1'b1, F3_SH, 32'h0000_1234, 0, rd, er);
        checkOutput("sh103_err", 32'(er), 32'd1);
        applyStimulus(32'h100, 1'b0, F3_LW, 32'h0, 0, rd, er);
        checkOutput("lw100_after_sh", rd, 32'hDEAD_A5EF);
        applyStimulus(32'h4000, 1'b0, F3_LW, 32'h0, 0, rd, er);
        checkOutput("lw4000_err", 32'(er), 32'd1);
        applyStimulus(32'h100, 1'b0, 3'b011, 32'h0, 0, rd, er);
        checkOutput("f3_011_err", 32'(er), 32'd1);

        $display("[TB] backpressure with a queued request");
        preValid = 1'b1;
        preAddr  = 32'h100;
        preWe    = 1'b0;
        preF3    = F3_LW;
        preWd    = 32'h0;
        applyStimulus(32'h101, 1'b0, F3_LBU, 32'h0, 5, rd, er);
        checkOutput("bp_rdata", rd, 32'h0000_00A5);
        preValid = 1'b0;
        prevHs   = lastHs;
        applyStimulus(32'h100, 1'b0, F3_LW, 32'h0, 0, rd, er);
        checkOutput("bp_next_accept", 32'(lastAcc - prevHs), 32'd1);
        checkOutput("bp_next_rdata", rd, 32'hDEAD_A5EF);

        $display("[TB] tohost halt");
        applyStimulus(TOHOST, 1'b1, F3_SW, 32'h1, 0, rd, er);
        @(negedge clk_i);
        checkOutput("halt_set", 32'(halt_o), 32'd1);
        @(posedge clk_i); #1;
        applyStimulus(TOHOST, 1'b1, F3_SW, 32'h0, 0, rd, er);
        @(negedge clk_i);
        checkOutput("halt_sticky", 32'(halt_o), 32'd1);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("halt_cleared", 32'(halt_o), 32'd0);
        @(posedge clk_i); #1;

        $display("[TB] reset during wait state");
        bus.req_addr_i  = 32'h200;
        bus.req_we_i    = 1'b1;
        bus.req_func3_i = F3_SW;
        bus.req_wdata_i = 32'h55;
        bus.req_valid_i = 1'b1;
        @(negedge clk_i);
        checkOutput("rstmid_accept", 32'(bus.req_ready_o), 32'd1);
        @(posedge clk_i); #1;
        bus.req_valid_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("rstmid_valid", 32'(bus.resp_valid_o), 32'd0);
        checkOutput("rstmid_idle", 32'(bus.req_ready_o), 32'd1);
        @(posedge clk_i); #1;
        applyStimulus(32'h200, 1'b0, F3_LW, 32'h0, 0, rd, er);
        checkOutput("rstmid_nowrite", rd, 32'h1122_3344);

        $display("[TB] randomized transactions");
        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 85)      a = 32'($urandom_range(0, 511));
            else if (r < 92) a = $urandom | 32'h0000_4000;
            else             a = TOHOST + 32'($urandom_range(0, 3));
            applyStimulus(a, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          $urandom, int'($urandom_range(0, 3)), rd, er);
        end

        repeat (2) @(posedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
